// File: rtl/pix_smooth_stream.sv
// pix_smooth_stream: streaming 3x3 smoothing filter (bypass / centre-weighted / Gaussian) over valid/ready
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   mode[1:0]                    kernel select, latched at input pixel (0,0)
//   s_valid, s_ready, s_pix      raster-ordered input stream
//   m_valid, m_ready, m_pix      registered filtered output stream
//   m_first, m_last              frame start/end markers, qualified by m_valid
module pix_smooth_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_pix,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_pix,
  output logic             m_first,
  output logic             m_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = PIX_W + 4;
  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] win [3][3];
  logic [PIX_W-1:0] nw [3][3];
  logic [CW-1:0] in_col, out_col;
  logic [RW-1:0] in_row, out_row;
  logic [1:0] frame_mode;
  logic acc, drain_step, adv, emit, in_end, out_end, border, in_wrap, out_wrap;
  logic [AW-1:0] ctr, edg, cor, avg, gau;
  logic [PIX_W-1:0] filt;
  assign s_ready = (state == FILL || state == RUN) && (!m_valid || m_ready);
  assign acc = s_valid && s_ready;
  // In DRAIN the window keeps stepping on virtual inputs; it stops once m_last is presented.
  assign drain_step = state == DRAIN && !(m_valid && m_last) && (!m_valid || m_ready);
  assign adv = acc || drain_step;
  assign emit = (state == RUN && acc) || drain_step;
  assign in_wrap = in_col == CW'(IMG_W - 1);
  assign out_wrap = out_col == CW'(IMG_W - 1);
  assign in_end = in_wrap && in_row == RW'(IMG_H - 1);
  assign out_end = out_wrap && out_row == RW'(IMG_H - 1);
  assign border = out_row == '0 || out_row == RW'(IMG_H - 1) || out_col == '0 || out_wrap;
  // Window after this step: shift left, new column = {two lines ago, one line ago, current}.
  // Its centre is always the pixel IMG_W+1 positions behind the newest one, i.e. the next output.
  // During DRAIN the bottom row is don't-care: every drained output is a border pixel.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nw[r][0] = win[r][1];
      nw[r][1] = win[r][2];
    end
    nw[0][2] = lb1[in_col];
    nw[1][2] = lb0[in_col];
    nw[2][2] = s_pix;
  end
  always_comb begin
    ctr = AW'(nw[1][1]);
    edg = AW'(nw[0][1]) + AW'(nw[2][1]) + AW'(nw[1][0]) + AW'(nw[1][2]);
    cor = AW'(nw[0][0]) + AW'(nw[0][2]) + AW'(nw[2][0]) + AW'(nw[2][2]);
    avg = (ctr << 3) + edg + cor;
    gau = (ctr << 2) + (edg << 1) + cor;
    filt = (border || frame_mode == 2'd0 || frame_mode == 2'd3) ? nw[1][1]
         : frame_mode == 2'd1 ? avg[AW-1:4] : gau[AW-1:4];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = FILL;
      FILL:  if (acc && in_row == RW'(1) && in_col == '0) state_nx = RUN;
      RUN:   if (acc && in_end) state_nx = DRAIN;
      DRAIN: if (m_valid && m_last && m_ready) state_nx = FILL;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      in_col <= '0;
      in_row <= '0;
      out_col <= '0;
      out_row <= '0;
      frame_mode <= '0;
    end else begin
      state <= state_nx;
      if (state == DRAIN && state_nx == FILL) begin
        in_col <= '0;
        in_row <= '0;
      end else if (adv) begin
        in_col <= in_wrap ? '0 : in_col + 1'b1;
        if (in_wrap) in_row <= in_row == RW'(IMG_H - 1) ? '0 : in_row + 1'b1;
      end
      if (emit) begin
        out_col <= out_wrap ? '0 : out_col + 1'b1;
        if (out_wrap) out_row <= out_end ? '0 : out_row + 1'b1;
      end
      if (acc && in_row == '0 && in_col == '0) frame_mode <= mode;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (adv) begin
      win <= nw;
    end
  end
  // Line buffers carry no reset; entries are only consumed after being written this frame.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1[in_col] <= lb0[in_col];
      lb0[in_col] <= s_pix;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_pix <= '0;
      m_first <= 1'b0;
      m_last <= 1'b0;
    end else if (emit) begin
      m_valid <= 1'b1;
      m_pix <= filt;
      m_first <= out_row == '0 && out_col == '0;
      m_last <= out_end;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pix_smooth_stream.sv
// tb_pix_smooth_stream: directed bench for pix_smooth_stream on a 4x4 and an 8x8 instance
module tb_pix_smooth_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic sv = 1'b0;
  logic mr = 1'b1;
  logic [7:0] sp = 8'd0;
  logic [1:0] md = 2'd0;
  logic sv4, sv8, mr4, mr8, sr4, sr8, mv4, mv8, mf4, mf8, ml4, ml8;
  logic [7:0] mp4, mp8;
  logic c_sr, c_mv, c_mf, c_ml;
  logic [7:0] c_mp;
  int errors = 0;
  int checks = 0;
  logic [7:0] in_px [64];
  logic [7:0] exp_px [64];
  logic [7:0] o_px [64];
  logic [7:0] ref_px [64];
  logic o_f [64];
  logic o_l [64];
  always #5 clk = ~clk;
  assign sv4 = sv & ~sel;
  assign sv8 = sv & sel;
  assign mr4 = mr | sel;
  assign mr8 = mr | ~sel;
  assign c_sr = sel ? sr8 : sr4;
  assign c_mv = sel ? mv8 : mv4;
  assign c_mp = sel ? mp8 : mp4;
  assign c_mf = sel ? mf8 : mf4;
  assign c_ml = sel ? ml8 : ml4;
  pix_smooth_stream #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) d4 (
    .clk(clk), .rst(rst), .mode(md), .s_valid(sv4), .s_ready(sr4), .s_pix(sp),
    .m_valid(mv4), .m_ready(mr4), .m_pix(mp4), .m_first(mf4), .m_last(ml4));
  pix_smooth_stream #(.PIX_W(8), .IMG_W(8), .IMG_H(8)) d8 (
    .clk(clk), .rst(rst), .mode(md), .s_valid(sv8), .s_ready(sr8), .s_pix(sp),
    .m_valid(mv8), .m_ready(mr8), .m_pix(mp8), .m_first(mf8), .m_last(ml8));
  // Streams n pixels from in_px into the selected instance and collects n outputs.
  // mode is ma for the first three inputs and mb afterwards; gaps adds input bubbles and m_ready 1,0,0,1.
  task automatic run(input int n, input logic [1:0] ma, input logic [1:0] mb, input bit gaps);
    int ii = 0;
    int nout = 0;
    int cyc = 0;
    bit pst = 0;
    logic [7:0] ppx = 8'd0;
    while (nout < n && cyc < 3000) begin
      @(negedge clk);
      md = ii < 3 ? ma : mb;
      sv = (ii < n) && (!gaps || cyc % 5 != 2);
      sp = ii < n ? in_px[ii] : 8'd0;
      mr = !gaps || cyc % 4 == 0 || cyc % 4 == 3;
      #1;
      if (pst) begin
        checks++;
        if (c_mv !== 1'b1 || c_mp !== ppx) begin
          errors++;
          $display("FAIL stall_hold cyc %0d got valid=%0b pix=%0d want valid=1 pix=%0d", cyc, c_mv, c_mp, ppx);
        end
      end
      pst = c_mv && !mr;
      ppx = c_mp;
      if (sv && c_sr) ii++;
      if (c_mv && mr) begin
        o_px[nout] = c_mp;
        o_f[nout] = c_mf;
        o_l[nout] = c_ml;
        nout++;
      end
      cyc++;
    end
    @(negedge clk);
    sv = 1'b0;
    mr = 1'b1;
    checks++;
    if (nout != n) begin
      errors++;
      $display("FAIL frame_count got %0d outputs want %0d", nout, n);
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (c_sr !== 1'b0 || c_mv !== 1'b0 || c_mp !== 8'd0 || c_mf !== 1'b0 || c_ml !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got sr=%0b mv=%0b pix=%0d f=%0b l=%0b want all 0", c_sr, c_mv, c_mp, c_mf, c_ml);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (c_sr !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got %0b want 0", c_sr);
    end
    @(negedge clk);
    #1;
    checks++;
    if (c_sr !== 1'b1) begin
      errors++;
      $display("FAIL fill_ready got %0b want 1", c_sr);
    end
  endtask
  task automatic test_uniform();
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 16; i++) in_px[i] = 8'd100;
      run(16, 2'(m), 2'(m), 0);
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (o_px[i] !== 8'd100) begin
          errors++;
          $display("FAIL uniform m%0d pix[%0d] got %0d want 100", m, i, o_px[i]);
        end
        checks++;
        if (o_f[i] !== (i == 0) || o_l[i] !== (i == 15)) begin
          errors++;
          $display("FAIL uniform m%0d flags[%0d] got f=%0b l=%0b want f=%0b l=%0b", m, i, o_f[i], o_l[i], i == 0, i == 15);
        end
      end
    end
  endtask
  // Mode is switched after the third input each time; the frame must keep the mode latched at (0,0).
  task automatic test_impulse();
    for (int m = 1; m < 3; m++) begin
      for (int i = 0; i < 16; i++) begin
        in_px[i] = 8'd0;
        exp_px[i] = 8'd0;
      end
      in_px[5] = 8'd160;
      exp_px[5] = m == 1 ? 8'd80 : 8'd40;
      exp_px[6] = m == 1 ? 8'd10 : 8'd20;
      exp_px[9] = m == 1 ? 8'd10 : 8'd20;
      exp_px[10] = 8'd10;
      run(16, 2'(m), 2'(3 - m), 0);
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (o_px[i] !== exp_px[i]) begin
          errors++;
          $display("FAIL impulse m%0d pix[%0d] got %0d want %0d", m, i, o_px[i], exp_px[i]);
        end
      end
    end
  endtask
  task automatic test_border();
    for (int i = 0; i < 16; i++) begin
      in_px[i] = 8'd0;
      exp_px[i] = 8'd0;
    end
    in_px[0] = 8'd200;
    in_px[14] = 8'd48;
    exp_px[0] = 8'd200;
    exp_px[14] = 8'd48;
    exp_px[5] = 8'd12;
    exp_px[9] = 8'd3;
    exp_px[10] = 8'd6;
    run(16, 2'd2, 2'd2, 0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (o_px[i] !== exp_px[i]) begin
        errors++;
        $display("FAIL border pix[%0d] got %0d want %0d", i, o_px[i], exp_px[i]);
      end
    end
  endtask
  task automatic test_max();
    for (int i = 0; i < 16; i++) in_px[i] = 8'd255;
    run(16, 2'd2, 2'd2, 0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (o_px[i] !== 8'd255) begin
        errors++;
        $display("FAIL max pix[%0d] got %0d want 255", i, o_px[i]);
      end
    end
  endtask
  // A linear ramp is a fixed point of the Gaussian kernel, so every output equals its input.
  task automatic test_backpressure();
    sel = 1'b1;
    for (int i = 0; i < 64; i++) in_px[i] = 8'(3 * (i / 8) + i % 8);
    run(64, 2'd2, 2'd2, 0);
    for (int i = 0; i < 64; i++) begin
      ref_px[i] = o_px[i];
      checks++;
      if (o_px[i] !== in_px[i] || o_f[i] !== (i == 0) || o_l[i] !== (i == 63)) begin
        errors++;
        $display("FAIL ramp_free [%0d] got pix=%0d f=%0b l=%0b want pix=%0d f=%0b l=%0b", i, o_px[i], o_f[i], o_l[i], in_px[i], i == 0, i == 63);
      end
    end
    run(64, 2'd2, 2'd2, 1);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (o_px[i] !== ref_px[i] || o_px[i] !== in_px[i]) begin
        errors++;
        $display("FAIL ramp_stall [%0d] got %0d want %0d", i, o_px[i], in_px[i]);
      end
    end
    sel = 1'b0;
  endtask
  task automatic test_reset_mid();
    int ii = 0;
    int cyc = 0;
    md = 2'd2;
    while (ii < 10 && cyc < 200) begin
      @(negedge clk);
      sv = 1'b1;
      sp = 8'd77;
      mr = 1'b1;
      #1;
      if (c_sr) ii++;
      cyc++;
    end
    @(negedge clk);
    sv = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (c_mv !== 1'b0 || c_sr !== 1'b0 || c_mp !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got mv=%0b sr=%0b pix=%0d want 0 0 0", c_mv, c_sr, c_mp);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_px[i] = 8'd0;
      exp_px[i] = 8'd0;
    end
    in_px[5] = 8'd160;
    exp_px[5] = 8'd80;
    exp_px[6] = 8'd10;
    exp_px[9] = 8'd10;
    exp_px[10] = 8'd10;
    run(16, 2'd1, 2'd1, 0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (o_px[i] !== exp_px[i] || o_f[i] !== (i == 0) || o_l[i] !== (i == 15)) begin
        errors++;
        $display("FAIL after_reset [%0d] got pix=%0d f=%0b l=%0b want pix=%0d f=%0b l=%0b", i, o_px[i], o_f[i], o_l[i], exp_px[i], i == 0, i == 15);
      end
    end
  endtask
  initial begin
    test_reset();
    test_uniform();
    test_impulse();
    test_border();
    test_max();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
